ring_gate_meter: RTL
====================

# ring_gate_meter

Parametrised multi-channel ring-oscillator frequency meter for the ring-oscillator test top. It takes free-running Gray-coded counters clocked by pCHANNELS ring oscillators and measures each one against a gate window timed in i_clk cycles. The window is built from short sub-intervals, so the per-channel count can be wider than the ring-domain counter. Unlike the fixed capture/scan path, it adds configurable channel count and width, a programmable gate, saturating accumulation with overflow flags, and single-shot or gap-free continuous mode. It sits between the ring-domain Gray counters and the LED scan/readout logic.

## Interface
- pCHANNELS, 4: number of ring channels, ≥1
- pGREY_W, 10: width of each incoming Gray counter
- pACC_W, 24: per-channel accumulator/result width, ≥ pGREY_W
- pSUB, 64: sub-interval length in i_clk cycles, 2..2^(pGREY_W-1)
- pGATE_W, 16: width of gate length input

Ports:
- i_clk  in  1  system clock; the only clock of the block
- i_rst_n  in  1  synchronous, active-low reset
- i_grey  in  pCHANNELS*pGREY_W  Gray counters, channel k at bits [k*pGREY_W +: pGREY_W]; asynchronous to i_clk
- i_start  in  1  start request, level-sampled
- i_mode  in  1  0 = single shot, 1 = continuous
- i_gate  in  pGATE_W  gate length G, in sub-intervals
- i_sel  in  max(1,$clog2(pCHANNELS))  readout channel select
- o_count  out  pACC_W  result of selected channel, registered
- o_ovf  out  1  overflow flag of selected channel, registered
- o_valid  out  1  results hold at least one completed window
- o_done  out  1  one-cycle pulse per completed window
- o_busy  out  1  measurement in progress

## Operation
- Synchronise every i_grey bit with a 2-flop synchroniser. Gray coding makes a multi-bit sample safe. Convert each synchronised value to binary: bin[W-1] = g[W-1], bin[i] = bin[i+1]^g[i].
- States are IDLE, PRIME, RUN, LATCH.
- IDLE: o_busy = 0. If i_start = 1 and i_gate ≠ 0, latch G = i_gate and go to PRIME. If i_gate = 0, ignore i_start.
- PRIME: for every channel, prev ← bin and acc ← 0, clear the per-channel ovf bit, and clear the sub counter. Go to RUN.
- RUN: the sub counter counts 0..pSUB-1. When it reaches pSUB-1, per channel:
  - delta = (bin − prev) mod 2^pGREY_W
  - acc ← acc + delta, saturating at all-ones
  - set the channel's ovf bit if saturation occurs
  - prev ← bin
  - decrement the remaining-gate count
- RUN exit: after the G-th update, go to LATCH.
- LATCH:
  - For every channel, result ← acc and result_ovf ← ovf. Set o_valid = 1 and pulse o_done.
  - If i_mode = 1, go to RUN: acc ← 0, ovf ← 0, sub counter ← 0, reload G. prev is not touched, so no ring edge is lost or double-counted.
  - If i_mode = 0, go to IDLE.
- i_mode is sampled only in LATCH. Dropping it mid-window finishes the current window, then the block returns to IDLE.
- i_start is ignored outside IDLE. i_gate is sampled only on acceptance.
- Readout: o_count/o_ovf ← result[i_sel]/result_ovf[i_sel] every cycle. If i_sel ≥ pCHANNELS, drive 0.
- Results are held until the next LATCH. A new start does not clear o_valid.
- Wrap-around: a correct delta requires fewer than 2^pGREY_W ring edges per sub-interval plus sync skew. Choosing pSUB to meet this is the integrator's responsibility; the block does not detect violations.

## Timing
- Reset (i_rst_n = 0 at an edge): state IDLE; o_count = 0, o_ovf = 0, o_valid = 0, o_done = 0, o_busy = 0. All results, acc, prev, ovf and synchronisers clear. Reset wins over any simultaneous start or update, including mid-RUN.
- Input latency: 2 cycles from i_grey to bin.
- Edge E0 accepts start → PRIME. Edge E1 does PRIME. Update k happens at edge E1+k·pSUB.
- The final update is at E1+G·pSUB. LATCH at E2+G·pSUB; o_done is high for the cycle following that edge.
- o_count is valid 1 cycle after LATCH or after an i_sel change.
- o_busy is 1 from the cycle after E0 through the LATCH cycle of the last window.
- Continuous windows after the first are G·pSUB+1 cycles long, because the LATCH cycle is included.

## Test plan
- Reset: drive i_rst_n = 0 mid-RUN with G = 4 → next cycle all outputs 0, state IDLE; a new start after release behaves normally.
- Single shot, pSUB = 64, G = 4: ch0 Gray counter +1 every 4 i_clk, synchronous to i_clk → o_done at E0+258, o_count(ch0) = 64, o_ovf = 0, o_valid = 1; a channel held constant reads 0.
- Wrap: pGREY_W = 10, ch1 starts at 1000 and steps +1 per cycle, G = 2 → o_count(ch1) = 128, correct across the 1023→0 wrap.
- Saturation: pACC_W = 10, ch2 steps +1 per cycle, G = 32 (2048 edges) → o_count = 1023, o_ovf = 1.
- Continuous: i_mode = 1, G = 2, ch0 steps +1 per cycle → first window 128, subsequent windows 129. Summed results equal the total edges since PRIME. Dropping i_mode mid-window → exactly one more o_done, then o_busy = 0.
- Start handling: i_start held high during RUN → no restart, and exactly one o_done per window in single mode. i_gate = 0 with i_start → o_busy stays 0. i_sel = pCHANNELS → o_count = 0.

Source files
------------

// File: rtl/ring_gate_meter.sv
// ring_gate_meter: multi-channel ring-oscillator frequency meter built from Gray-counter sub-interval deltas.
// Gated, saturating per-channel accumulation with single-shot or gap-free continuous windows.
module ring_gate_meter #(
    parameter int pCHANNELS = 4,
    parameter int pGREY_W   = 10,
    parameter int pACC_W    = 24,
    parameter int pSUB      = 64,
    parameter int pGATE_W   = 16,
    localparam int pSEL_W   = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1,
    localparam int pSUB_W   = $clog2(pSUB)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [pCHANNELS*pGREY_W-1:0] i_grey,
    input  logic                         i_start,
    input  logic                         i_mode,
    input  logic [pGATE_W-1:0]           i_gate,
    input  logic [pSEL_W-1:0]            i_sel,
    output logic [pACC_W-1:0]            o_count,
    output logic                         o_ovf,
    output logic                         o_valid,
    output logic                         o_done,
    output logic                         o_busy
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN, LATCH} state_t;

    state_t                      state, state_nx;
    logic [pCHANNELS*pGREY_W-1:0] sync1, sync2;
    logic [pGREY_W-1:0]          bin    [pCHANNELS];
    logic [pGREY_W-1:0]          prev   [pCHANNELS];
    logic [pGREY_W-1:0]          delta  [pCHANNELS];
    logic [pACC_W:0]             sum    [pCHANNELS];
    logic [pACC_W-1:0]           acc    [pCHANNELS];
    logic [pACC_W-1:0]           result [pCHANNELS];
    logic [pCHANNELS-1:0]        ovf, result_ovf;
    logic [pSUB_W-1:0]           sub;
    logic [pGATE_W-1:0]          gate, remain;
    logic                        accept, tick, prime, latch;

    function automatic logic [pGREY_W-1:0] g2b(input logic [pGREY_W-1:0] g);
        for (int i = 0; i < pGREY_W; i++)
            g2b[i] = ^(g >> i);
    endfunction

    always_comb begin
        for (int c = 0; c < pCHANNELS; c++) begin
            bin[c]   = g2b(sync2[c*pGREY_W +: pGREY_W]);
            delta[c] = bin[c] - prev[c];
            sum[c]   = {1'b0, acc[c]} + (pACC_W+1)'(delta[c]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (i_start && i_gate != '0) ? PRIME : IDLE;
            PRIME:   state_nx = RUN;
            RUN:     state_nx = (tick && remain == pGATE_W'(1)) ? LATCH : RUN;
            default: state_nx = i_mode ? RUN : IDLE;
        endcase
    end

    always_comb begin
        accept = state == IDLE && i_start && i_gate != '0;
        prime  = state == PRIME;
        latch  = state == LATCH;
        tick   = state == RUN && sub == pSUB_W'(pSUB - 1);
        o_busy = state != IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            gate       <= '0;
            remain     <= '0;
            sub        <= '0;
            ovf        <= '0;
            result_ovf <= '0;
            o_count    <= '0;
            o_ovf      <= 1'b0;
            o_valid    <= 1'b0;
            o_done     <= 1'b0;
            for (int c = 0; c < pCHANNELS; c++) begin
                prev[c]   <= '0;
                acc[c]    <= '0;
                result[c] <= '0;
            end
        end else begin
            sync1   <= i_grey;
            sync2   <= sync1;
            o_done  <= latch;
            o_count <= (32'(i_sel) < pCHANNELS) ? result[i_sel] : '0;
            o_ovf   <= (32'(i_sel) < pCHANNELS) ? result_ovf[i_sel] : 1'b0;
            if (accept)
                gate <= i_gate;
            if (prime || latch) begin
                remain <= gate;
                sub    <= '0;
                ovf    <= '0;
                for (int c = 0; c < pCHANNELS; c++)
                    acc[c] <= '0;
            end
            if (prime)
                for (int c = 0; c < pCHANNELS; c++)
                    prev[c] <= bin[c];
            // prev is left alone in LATCH so back-to-back windows share their boundary sample
            if (latch) begin
                result_ovf <= ovf;
                o_valid    <= 1'b1;
                for (int c = 0; c < pCHANNELS; c++)
                    result[c] <= acc[c];
            end
            if (state == RUN)
                sub <= tick ? '0 : sub + pSUB_W'(1);
            if (tick) begin
                remain <= remain - pGATE_W'(1);
                for (int c = 0; c < pCHANNELS; c++) begin
                    prev[c] <= bin[c];
                    acc[c]  <= sum[c][pACC_W] ? '1 : sum[c][pACC_W-1:0];
                    if (sum[c][pACC_W])
                        ovf[c] <= 1'b1;
                end
            end
        end
    end
endmodule
